// File: rtl/intr_ctrl_pkg.sv
// Shared types and register-map helpers for the APB interrupt controller.
package intr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARB      = 2'd1,
        WAIT_SVC = 2'd2
    } state_e;

    function automatic int unsigned enable_off(input int unsigned num_intr);
        return num_intr;
    endfunction

    function automatic int unsigned pend_off(input int unsigned num_intr);
        return num_intr + 1;
    endfunction

    function automatic int unsigned ctrl_off(input int unsigned num_intr);
        return num_intr + 2;
    endfunction

endpackage

// File: rtl/intr_prio_arbiter.sv
// Combinational max-priority arbiter; ties resolve to the lowest source index.
module intr_prio_arbiter
    import intr_ctrl_pkg::*;
#(
    parameter int unsigned NUM_INTR = 16,
    parameter int unsigned PRIO_W   = 4
) (
    input  logic [NUM_INTR-1:0]         eligible,
    input  logic [NUM_INTR*PRIO_W-1:0]  prio_flat,
    output logic [$clog2(NUM_INTR)-1:0] win_idx,
    output logic [PRIO_W-1:0]           win_prio,
    output logic                        any
);

    localparam int unsigned IDX_W = $clog2(NUM_INTR);

    // Ascending scan with strict '>' keeps the lowest index on equal priority.
    always_comb begin
        win_idx  = '0;
        win_prio = '0;
        any      = 1'b0;
        for (int i = 0; i < int'(NUM_INTR); i++) begin
            if (eligible[i] && (!any || prio_flat[i*PRIO_W +: PRIO_W] > win_prio)) begin
                win_idx  = IDX_W'(i);
                win_prio = prio_flat[i*PRIO_W +: PRIO_W];
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_intr_ctrl_param.sv
// APB-programmable interrupt controller: per-source priority/enable, sticky pending,
// max-priority arbitration and a valid/serviced handshake toward the CPU.
module apb_intr_ctrl_param
    import intr_ctrl_pkg::*;
#(
    parameter int unsigned NUM_INTR = 16,
    parameter int unsigned PRIO_W   = 4,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned PREEMPT  = 0
) (
    input  logic                        pclk,
    input  logic                        prst,
    input  logic                        psel,
    input  logic                        penable,
    input  logic                        pwrite,
    input  logic [ADDR_W-1:0]           paddr,
    input  logic [31:0]                 pwdata,
    output logic [31:0]                 prdata,
    output logic                        pready,
    output logic                        pslverr,
    input  logic [NUM_INTR-1:0]         intr_active,
    input  logic                        intr_serviced,
    output logic                        intr_valid,
    output logic [$clog2(NUM_INTR)-1:0] intr_to_service,
    output logic [PRIO_W-1:0]           intr_prio
);

    localparam int unsigned IDX_W    = $clog2(NUM_INTR);
    localparam int unsigned ENABLE_A = enable_off(NUM_INTR);
    localparam int unsigned PEND_A   = pend_off(NUM_INTR);
    localparam int unsigned CTRL_A   = ctrl_off(NUM_INTR);

    logic [NUM_INTR-1:0][PRIO_W-1:0] prio_q;
    logic [NUM_INTR-1:0]             enable_q;
    logic [NUM_INTR-1:0]             pend_q;
    logic [NUM_INTR-1:0]             pend_d;
    logic [NUM_INTR-1:0]             pend_clr;
    logic [NUM_INTR-1:0]             eligible;
    logic [NUM_INTR-1:0]             other_elig;
    logic                            gen_q;

    logic [31:0]       addr_w;
    logic              access;
    logic              addr_err;
    logic              wr_en;
    logic              rd_en;
    logic              w1c;

    logic [IDX_W-1:0]  win_idx;
    logic [PRIO_W-1:0] win_prio;
    logic              win_any;

    state_e            state_q;
    state_e            state_d;
    logic              ld_win;
    logic              set_valid;
    logic              svc_done;

    logic              unused_pwdata;
    assign unused_pwdata = ^pwdata;

    // APB decode: zero wait states, out-of-map accesses error out with no side effect.
    assign addr_w   = 32'(paddr);
    assign access   = psel & penable;
    assign addr_err = addr_w > CTRL_A;
    assign wr_en    = access & pwrite & ~addr_err;
    assign rd_en    = access & ~pwrite & ~addr_err;
    assign w1c      = wr_en & (addr_w == PEND_A);
    assign pready   = access;
    assign pslverr  = access & addr_err;

    always_comb begin
        prdata = '0;
        if (rd_en) begin
            for (int i = 0; i < int'(NUM_INTR); i++) begin
                if (addr_w == 32'(i)) prdata = 32'(prio_q[i]);
            end
            if (addr_w == ENABLE_A) prdata = 32'(enable_q);
            if (addr_w == PEND_A)   prdata = 32'(pend_q);
            if (addr_w == CTRL_A)   prdata = 32'(gen_q);
        end
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            prio_q   <= '0;
            enable_q <= '0;
            gen_q    <= 1'b0;
        end else if (wr_en) begin
            for (int i = 0; i < int'(NUM_INTR); i++) begin
                if (addr_w == 32'(i)) prio_q[i] <= pwdata[PRIO_W-1:0];
            end
            if (addr_w == ENABLE_A) enable_q <= pwdata[NUM_INTR-1:0];
            if (addr_w == CTRL_A)   gen_q    <= pwdata[0];
        end
    end

    // Sticky pending: a sampled enabled request overrides any same-cycle clear.
    always_comb begin
        pend_clr   = '0;
        other_elig = '0;
        for (int i = 0; i < int'(NUM_INTR); i++) begin
            pend_clr[i]   = (w1c & pwdata[i]) | (svc_done & (intr_to_service == IDX_W'(i)));
            other_elig[i] = eligible[i] & (intr_to_service != IDX_W'(i));
        end
        pend_d = (intr_active & enable_q) | (pend_q & ~pend_clr);
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) pend_q <= '0;
        else      pend_q <= pend_d;
    end

    assign eligible = pend_q & enable_q;

    intr_prio_arbiter #(
        .NUM_INTR (NUM_INTR),
        .PRIO_W   (PRIO_W)
    ) u_arb (
        .eligible  (eligible),
        .prio_flat (prio_q),
        .win_idx   (win_idx),
        .win_prio  (win_prio),
        .any       (win_any)
    );

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (gen_q && win_any) state_d = ARB;
            ARB:      state_d = win_any ? WAIT_SVC : IDLE;
            WAIT_SVC: if (intr_serviced) state_d = (gen_q && |other_elig) ? ARB : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Preemption only swaps in a strictly more urgent source while still awaiting service.
    always_comb begin
        set_valid = (state_q == ARB) && win_any;
        svc_done  = (state_q == WAIT_SVC) && intr_serviced;
        ld_win    = set_valid;
        if ((PREEMPT != 0) && (state_q == WAIT_SVC) && !intr_serviced && gen_q &&
            win_any && (win_prio > intr_prio)) begin
            ld_win = 1'b1;
        end
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            intr_valid      <= 1'b0;
            intr_to_service <= '0;
            intr_prio       <= '0;
        end else begin
            if (svc_done)       intr_valid <= 1'b0;
            else if (set_valid) intr_valid <= 1'b1;
            if (ld_win) begin
                intr_to_service <= win_idx;
                intr_prio       <= win_prio;
            end
        end
    end

endmodule

// File: tb/tb_apb_intr_ctrl_param.sv
// Bench for apb_intr_ctrl_param: one non-preempting and one preempting instance,
// directed scenarios plus randomized configurations checked against a service-order model.
module tb_apb_intr_ctrl_param;

    localparam int unsigned N  = 16;
    localparam int unsigned PW = 4;
    localparam int unsigned AW = 6;
    localparam int unsigned IW = $clog2(N);

    logic          pclk = 1'b0;
    logic          prst;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic [N-1:0]  intr_active;
    logic          intr_serviced;
    logic          tgt;

    logic psel0, psel1, srv0, srv1;
    logic [N-1:0] act0, act1;
    logic [31:0] prdata0, prdata1;
    logic pready0, pready1, pslverr0, pslverr1, valid0, valid1;
    logic [IW-1:0] idx0, idx1;
    logic [PW-1:0] prio0, prio1;

    logic [31:0]   cur_prdata;
    logic          cur_err, cur_valid;
    logic [IW-1:0] cur_idx;
    logic [PW-1:0] cur_prio;

    int vectors = 0;
    int errors  = 0;
    int m_prio [N];
    int exp_q [$];

    always #5 pclk = ~pclk;

    assign psel0 = psel & (tgt == 1'b0);
    assign psel1 = psel & (tgt == 1'b1);
    assign srv0  = intr_serviced & (tgt == 1'b0);
    assign srv1  = intr_serviced & (tgt == 1'b1);
    assign act0  = (tgt == 1'b0) ? intr_active : '0;
    assign act1  = (tgt == 1'b1) ? intr_active : '0;

    assign cur_prdata = tgt ? prdata1  : prdata0;
    assign cur_err    = tgt ? pslverr1 : pslverr0;
    assign cur_valid  = tgt ? valid1   : valid0;
    assign cur_idx    = tgt ? idx1     : idx0;
    assign cur_prio   = tgt ? prio1    : prio0;

    apb_intr_ctrl_param #(.NUM_INTR(N), .PRIO_W(PW), .ADDR_W(AW), .PREEMPT(0)) u_dut0 (
        .pclk(pclk), .prst(prst), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
        .intr_active(act0), .intr_serviced(srv0), .intr_valid(valid0),
        .intr_to_service(idx0), .intr_prio(prio0)
    );

    apb_intr_ctrl_param #(.NUM_INTR(N), .PRIO_W(PW), .ADDR_W(AW), .PREEMPT(1)) u_dut1 (
        .pclk(pclk), .prst(prst), .psel(psel1), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata1), .pready(pready1), .pslverr(pslverr1),
        .intr_active(act1), .intr_serviced(srv1), .intr_valid(valid1),
        .intr_to_service(idx1), .intr_prio(prio1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic apb_wr(input int addr, input logic [31:0] data);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = AW'(addr); pwdata = data;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input int addr, output logic [31:0] data, output logic err);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = AW'(addr);
        @(posedge pclk); #1;
        penable = 1'b1;
        #1;
        data = cur_prdata;
        err  = cur_err;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int addr, input logic [31:0] exp);
        logic [31:0] d;
        logic e;
        apb_rd(addr, d, e);
        chk(tag, d, exp);
    endtask

    task automatic set_prio(input int i, input int p);
        m_prio[i] = p;
        apb_wr(i, 32'(p));
    endtask

    task automatic pulse(input logic [N-1:0] mask);
        @(posedge pclk); #1;
        intr_active = mask;
        @(posedge pclk); #1;
        intr_active = '0;
    endtask

    task automatic wait_valid(output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (cur_valid) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic service();
        intr_serviced = 1'b1;
        cyc(1);
        intr_serviced = 1'b0;
    endtask

    task automatic expect_service(input string tag, input int idx, input int pr);
        logic ok;
        wait_valid(ok);
        chk({tag, "_valid"}, 32'(ok), 32'd1);
        chk({tag, "_idx"}, 32'(cur_idx), 32'(idx));
        chk({tag, "_prio"}, 32'(cur_prio), 32'(pr));
        service();
    endtask

    // Service order from the rules: highest priority first, lowest index among equals.
    function automatic void build_order(input logic [N-1:0] mask);
        logic [N-1:0] m;
        int best;
        m = mask;
        exp_q.delete();
        while (m != '0) begin
            best = -1;
            for (int i = 0; i < int'(N); i++)
                if (m[i] && (best < 0 || m_prio[i] > m_prio[best])) best = i;
            exp_q.push_back(best);
            m[best] = 1'b0;
        end
    endfunction

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic e;
        logic [N-1:0] en, lines, wmask;
        logic gen;
        int ri;

        prst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        intr_active = '0; intr_serviced = 1'b0; tgt = 1'b0;
        for (int i = 0; i < int'(N); i++) m_prio[i] = 0;
        #1;
        chk("rst_valid0", 32'(valid0), 0);
        chk("rst_valid1", 32'(valid1), 0);
        cyc(3);
        prst = 1'b0;
        cyc(1);

        // Reset register state and error response.
        for (int a = 0; a < int'(N) + 3; a++) begin
            apb_rd(a, d, e);
            chk($sformatf("rst_reg%0d", a), d, 0);
            chk($sformatf("rst_err%0d", a), 32'(e), 0);
        end
        apb_rd(N + 3, d, e);
        chk("oob_err", 32'(e), 1);
        chk("oob_data", d, 0);
        apb_wr(N + 3, 32'hFFFF_FFFF);
        rd_chk("oob_wr_noeffect_en", N, 0);

        // Tie-break and priority ordering; PRIO write to the serviced source leaves intr_prio alone.
        set_prio(3, 5); set_prio(9, 5); set_prio(12, 2);
        apb_wr(N, 32'h1208);
        apb_wr(N + 2, 32'd1);
        rd_chk("prio3_rb", 3, 5);
        pulse(16'h1208);
        wait_valid(e);
        chk("ord_first_valid", 32'(e), 1);
        set_prio(3, 1);
        chk("prio_wr_svc_keep", 32'(cur_prio), 5);
        expect_service("ord0", 3, 5);
        expect_service("ord1", 9, 5);
        expect_service("ord2", 12, 2);
        cyc(3);
        chk("ord_idle", 32'(cur_valid), 0);
        rd_chk("ord_pend", N + 1, 0);

        // Disabled source never pends.
        pulse(16'h0010);
        rd_chk("dis_pend", N + 1, 0);
        cyc(4);
        chk("dis_valid", 32'(cur_valid), 0);

        // Single-cycle pulse: latency, W1C of the serviced bit, then idle W1C.
        set_prio(5, 3);
        apb_wr(N, 32'h0020);
        pulse(16'h0020);
        chk("lat_c0", 32'(cur_valid), 0);
        cyc(1);
        chk("lat_c1", 32'(cur_valid), 0);
        cyc(1);
        chk("lat_c2", 32'(cur_valid), 1);
        chk("lat_idx", 32'(cur_idx), 5);
        apb_wr(N + 1, 32'h0020);
        chk("w1c_svc_hold", 32'(cur_valid), 1);
        service();
        chk("svc_drop", 32'(cur_valid), 0);
        rd_chk("pulse_pend", N + 1, 0);
        apb_wr(N + 2, 32'd0);
        pulse(16'h0020);
        rd_chk("idle_pend_set", N + 1, 32'h0020);
        apb_wr(N + 1, 32'h0020);
        rd_chk("idle_pend_clr", N + 1, 0);
        apb_wr(N + 2, 32'd1);
        cyc(4);
        chk("idle_w1c_novalid", 32'(cur_valid), 0);

        // Preemption on/off with identical stimulus.
        for (int t = 1; t >= 0; t--) begin
            tgt = 1'(t);
            set_prio(1, 2); set_prio(7, 9);
            apb_wr(N, 32'h0082);
            apb_wr(N + 2, 32'd1);
            pulse(16'h0002);
            wait_valid(e);
            chk($sformatf("pre%0d_first", t), 32'(cur_idx), 1);
            pulse(16'h0080);
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("pre%0d_hold%0d", t, c), 32'(cur_valid), 1);
                cyc(1);
            end
            if (t == 1) begin
                chk("pre1_idx", 32'(cur_idx), 7);
                chk("pre1_prio", 32'(cur_prio), 9);
                expect_service("pre1_s0", 7, 9);
                expect_service("pre1_s1", 1, 2);
            end else begin
                chk("pre0_idx", 32'(cur_idx), 1);
                chk("pre0_prio", 32'(cur_prio), 2);
                expect_service("pre0_s0", 1, 2);
                expect_service("pre0_s1", 7, 9);
            end
            cyc(3);
            chk($sformatf("pre%0d_idle", t), 32'(cur_valid), 0);
        end

        // Reset during WAIT_SVC, then intr_serviced while idle.
        tgt = 1'b0;
        set_prio(2, 7);
        apb_wr(N, 32'h0004);
        apb_wr(N + 2, 32'd1);
        pulse(16'h0004);
        wait_valid(e);
        chk("mid_valid", 32'(cur_valid), 1);
        #3 prst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(valid0), 0);
        chk("mid_rst_prio", 32'(prio0), 0);
        chk("mid_rst_idx", 32'(idx0), 0);
        @(posedge pclk); #1;
        prst = 1'b0;
        for (int i = 0; i < int'(N); i++) m_prio[i] = 0;
        rd_chk("mid_rst_prio2", 2, 0);
        rd_chk("mid_rst_en", N, 0);
        rd_chk("mid_rst_ctrl", N + 2, 0);
        apb_wr(N, 32'h0004);
        apb_wr(N + 2, 32'd1);
        service();
        cyc(3);
        chk("idle_srv_valid", 32'(cur_valid), 0);
        pulse(16'h0004);
        expect_service("idle_srv_after", 2, 0);

        // Randomized configurations against the order model.
        for (int it = 0; it < 16; it++) begin
            tgt   = 1'(it % 2);
            en    = N'($urandom);
            lines = N'($urandom);
            gen   = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < int'(N); i++) set_prio(i, int'($urandom_range(0, 15)));
            apb_wr(N, 32'(en));
            apb_wr(N + 2, 32'(gen));
            ri = int'($urandom_range(0, N - 1));
            rd_chk($sformatf("r%0d_prio_rb", it), ri, 32'(m_prio[ri]));
            pulse(lines);
            rd_chk($sformatf("r%0d_pend", it), N + 1, 32'(lines & en));
            if (!gen) begin
                wmask = N'($urandom);
                apb_wr(N + 1, 32'(wmask));
                rd_chk($sformatf("r%0d_w1c", it), N + 1, 32'(lines & en & ~wmask));
                apb_wr(N + 1, 32'hFFFF_FFFF);
                chk($sformatf("r%0d_gen0_valid", it), 32'(cur_valid), 0);
            end else begin
                build_order(lines & en);
                foreach (exp_q[k])
                    expect_service($sformatf("r%0d_s%0d", it, k), exp_q[k], m_prio[exp_q[k]]);
            end
            cyc(3);
            chk($sformatf("r%0d_idle", it), 32'(cur_valid), 0);
            rd_chk($sformatf("r%0d_pend_end", it), N + 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
